// File: rtl/acc_cpu_gen2.sv
// Multi-cycle accumulator CPU: 16-op ISA, zero/carry flags, halt/resume,
// single shared req/ack memory port for fetch, load and store.
module acc_cpu_gen2 #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_resume,
    output logic [ADDR_W-1:0] o_pc,
    output logic [DATA_W-1:0] o_acc,
    output logic              o_zero,
    output logic              o_carry,
    output logic              o_halted,
    output logic              o_retire
);

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_LDA = 4'h1;
    localparam logic [OP_W-1:0] OP_STA = 4'h2;
    localparam logic [OP_W-1:0] OP_ADD = 4'h3;
    localparam logic [OP_W-1:0] OP_SUB = 4'h4;
    localparam logic [OP_W-1:0] OP_AND = 4'h5;
    localparam logic [OP_W-1:0] OP_OR  = 4'h6;
    localparam logic [OP_W-1:0] OP_XOR = 4'h7;
    localparam logic [OP_W-1:0] OP_LDI = 4'h8;
    localparam logic [OP_W-1:0] OP_JMP = 4'h9;
    localparam logic [OP_W-1:0] OP_JZ  = 4'hA;
    localparam logic [OP_W-1:0] OP_JNZ = 4'hB;
    localparam logic [OP_W-1:0] OP_SHL = 4'hC;
    localparam logic [OP_W-1:0] OP_SHR = 4'hD;
    localparam logic [OP_W-1:0] OP_NOT = 4'hE;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    if (DATA_W < ADDR_W + OP_W) begin : g_bad_width
        $error("acc_cpu_gen2: DATA_W must be >= ADDR_W + 4");
    end

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_RD,
        S_MEM_WR,
        S_HALT
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] ir;
    logic              zero;
    logic              carry;

    logic [OP_W-1:0]   opcode;
    logic [ADDR_W-1:0] operand;
    logic              is_mem_op;
    logic [DATA_W:0]   add_res;
    logic [DATA_W-1:0] alu_acc;
    logic              alu_carry;
    logic              unused_ir;

    assign opcode    = ir[DATA_W-1 -: OP_W];
    assign operand   = ir[ADDR_W-1:0];
    assign unused_ir = &{1'b0, ir};
    assign is_mem_op = (opcode >= OP_LDA) && (opcode <= OP_XOR);
    assign add_res   = {1'b0, acc} + {1'b0, i_mem_rdata};

    // Shared ALU: memory ops take M from the read bus, the rest use ACC/operand only.
    always_comb begin
        alu_acc   = acc;
        alu_carry = carry;
        case (opcode)
            OP_LDA: alu_acc = i_mem_rdata;
            OP_ADD: {alu_carry, alu_acc} = add_res;
            OP_SUB: begin
                alu_acc   = acc - i_mem_rdata;
                alu_carry = i_mem_rdata > acc;
            end
            OP_AND: alu_acc = acc & i_mem_rdata;
            OP_OR:  alu_acc = acc | i_mem_rdata;
            OP_XOR: alu_acc = acc ^ i_mem_rdata;
            OP_LDI: alu_acc = DATA_W'(operand);
            OP_SHL: begin
                alu_carry = acc[DATA_W-1];
                alu_acc   = {acc[DATA_W-2:0], 1'b0};
            end
            OP_SHR: begin
                alu_carry = acc[0];
                alu_acc   = {1'b0, acc[DATA_W-1:1]};
            end
            OP_NOT: alu_acc = ~acc;
            default: ;
        endcase
    end

    // Bus is decoded from registered state so it holds steady until ack; reset kills req at once.
    assign o_mem_req   = !i_rst && ((state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR));
    assign o_mem_we    = (state == S_MEM_WR);
    assign o_mem_addr  = (state == S_FETCH) ? pc : operand;
    assign o_mem_wdata = acc;
    assign o_retire    = !i_rst && (((state == S_DECODE) && !is_mem_op) ||
                         (((state == S_MEM_RD) || (state == S_MEM_WR)) && i_mem_ack));
    assign o_halted    = (state == S_HALT);
    assign o_pc        = pc;
    assign o_acc       = acc;
    assign o_zero      = zero;
    assign o_carry     = carry;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_FETCH;
            pc    <= ADDR_W'(RESET_PC);
            acc   <= '0;
            ir    <= '0;
            zero  <= 1'b0;
            carry <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (i_mem_ack) begin
                        ir    <= i_mem_rdata;
                        pc    <= pc + ADDR_W'(1);
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    state <= S_FETCH;
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state <= S_MEM_RD;
                        OP_STA: state <= S_MEM_WR;
                        OP_HLT: state <= S_HALT;
                        OP_JMP: pc <= operand;
                        OP_JZ:  if (zero)  pc <= operand;
                        OP_JNZ: if (!zero) pc <= operand;
                        OP_LDI, OP_SHL, OP_SHR, OP_NOT: begin
                            acc   <= alu_acc;
                            zero  <= (alu_acc == '0);
                            carry <= alu_carry;
                        end
                        default: ;
                    endcase
                end
                S_MEM_RD: begin
                    if (i_mem_ack) begin
                        acc   <= alu_acc;
                        zero  <= (alu_acc == '0);
                        carry <= alu_carry;
                        state <= S_FETCH;
                    end
                end
                S_MEM_WR: begin
                    if (i_mem_ack) state <= S_FETCH;
                end
                S_HALT: begin
                    if (i_resume) state <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_cpu_gen2.sv
// Bench for acc_cpu_gen2: memory responder with configurable wait states and an
// instruction-level reference model checked at every retired instruction.
module tb_acc_cpu_gen2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        resume = 1'b0;
    logic        mem_ack_r = 1'b0;
    logic        force_ack = 1'b0;
    logic        mem_ack;
    logic [15:0] mem_rdata = 16'h0;

    logic        mem_req, mem_we, zero, carry, halted, retire;
    logic [7:0]  mem_addr, pc;
    logic [15:0] mem_wdata, acc;

    logic        req2, we2, zero2, carry2, halted2, retire2;
    logic [7:0]  addr2, pc2;
    logic [15:0] wdata2, acc2;

    logic [15:0] mem  [256];
    logic [15:0] mmem [256];
    logic [7:0]  mpc;
    logic [15:0] macc;
    logic        mz, mc;

    int checks = 0;
    int errors = 0;
    int retire_cnt = 0;
    int cnt = 0;
    int lat = 0;
    bit rand_lat = 0;
    bit spur = 0;
    bit pend_chk = 0;
    bit prev_pend = 0;
    logic        prev_we;
    logic [7:0]  prev_addr, prev_pc;
    logic [15:0] prev_wdata, prev_acc;

    assign mem_ack = mem_ack_r | force_ack;

    always #5 clk = ~clk;

    acc_cpu_gen2 #(.DATA_W(16), .ADDR_W(8), .RESET_PC(0)) dut (
        .i_clk(clk), .i_rst(rst),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata), .i_resume(resume),
        .o_pc(pc), .o_acc(acc), .o_zero(zero), .o_carry(carry),
        .o_halted(halted), .o_retire(retire)
    );

    // Second core: reset vector at the top of the address space, always fed NOPs.
    acc_cpu_gen2 #(.DATA_W(16), .ADDR_W(8), .RESET_PC(255)) dut2 (
        .i_clk(clk), .i_rst(rst),
        .o_mem_req(req2), .o_mem_we(we2), .o_mem_addr(addr2), .o_mem_wdata(wdata2),
        .i_mem_ack(1'b1), .i_mem_rdata(16'h0000), .i_resume(1'b0),
        .o_pc(pc2), .o_acc(acc2), .o_zero(zero2), .o_carry(carry2),
        .o_halted(halted2), .o_retire(retire2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Architectural effect of one instruction, straight from the ISA table.
    task automatic model_step();
        logic [15:0] ins;
        logic [3:0]  op;
        logic [7:0]  opd;
        logic [15:0] m;
        int          sum;
        ins = mmem[mpc];
        op  = ins[15:12];
        opd = ins[7:0];
        m   = mmem[opd];
        mpc = mpc + 8'd1;
        case (op)
            4'h1: macc = m;
            4'h2: mmem[opd] = macc;
            4'h3: begin
                sum  = int'(macc) + int'(m);
                mc   = sum > 65535;
                macc = 16'(sum);
            end
            4'h4: begin
                mc   = m > macc;
                macc = macc - m;
            end
            4'h5: macc = macc & m;
            4'h6: macc = macc | m;
            4'h7: macc = macc ^ m;
            4'h8: macc = {8'h00, opd};
            4'h9: mpc = opd;
            4'hA: if (mz) mpc = opd;
            4'hB: if (!mz) mpc = opd;
            4'hC: begin mc = macc[15]; macc = macc * 16'd2; end
            4'hD: begin mc = macc[0];  macc = macc / 16'd2; end
            4'hE: macc = 16'hFFFF - macc;
            default: ;
        endcase
        if (op inside {4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hC, 4'hD, 4'hE})
            mz = (macc == 16'h0);
    endtask

    // Rising edge: memory writes, model step on retire, bus-hold checks while a request waits.
    always @(posedge clk) begin
        if (mem_req && mem_ack && mem_we) mem[mem_addr] = mem_wdata;
        if (rst) begin
            mpc = 8'h00; macc = 16'h0; mz = 1'b0; mc = 1'b0;
            retire_cnt = 0; pend_chk = 0; prev_pend = 0;
        end else begin
            if (prev_pend) begin
                chk("hold_bus", 32'({mem_req, mem_we, mem_addr, pc}), 32'({1'b1, prev_we, prev_addr, prev_pc}));
                chk("hold_data", 32'({mem_wdata, acc}), 32'({prev_wdata, prev_acc}));
            end
            if (retire) begin
                model_step();
                retire_cnt++;
                pend_chk = 1;
            end
            prev_pend  = mem_req && !mem_ack;
            prev_we    = mem_we;
            prev_addr  = mem_addr;
            prev_pc    = pc;
            prev_wdata = mem_wdata;
            prev_acc   = acc;
        end
    end

    // Falling edge: compare post-retire state, then drive the memory response.
    always @(negedge clk) begin
        if (pend_chk) begin
            pend_chk = 0;
            chk("retire_pc_flags", 32'({pc, zero, carry}), 32'({mpc, mz, mc}));
            chk("retire_acc", 32'(acc), 32'(macc));
        end
        if (mem_ack_r) begin
            cnt = 0;
            if (rand_lat) lat = $urandom_range(0, 3);
        end
        if (rst || !mem_req) begin
            mem_ack_r = spur && !mem_req;
            cnt       = 0;
            mem_rdata = 16'($urandom);
        end else if (cnt >= lat) begin
            mem_ack_r = 1'b1;
            mem_rdata = mem[mem_addr];
        end else begin
            mem_ack_r = 1'b0;
            cnt++;
            mem_rdata = 16'($urandom);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [15:0] d);
        mem[a]  = d;
        mmem[a] = d;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) load(i, 16'h0000);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        tick();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_halt(input string tag, input int max);
        int n = 0;
        while (!halted && n < max) begin
            tick();
            n++;
        end
        chk(tag, 32'(halted), 32'd1);
    endtask

    task automatic load_prog1();
        clear_mem();
        load(0, 16'h8005);
        load(1, 16'h3010);
        load(2, 16'h2011);
        load(3, 16'hF000);
        load(4, 16'hF000);
        load(16, 16'h0003);
    endtask

    initial begin
        int found;
        int mism;

        // Zero-wait program, reset state, exact halt latency, PC wrap on second core.
        load_prog1();
        tick();
        tick();
        chk("rst_no_req", 32'({mem_req, req2}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("rst_state", 32'({pc, zero, carry, halted, retire}), 32'h0);
        chk("rst_acc", 32'(acc), 32'd0);
        chk("first_fetch", 32'({mem_req, mem_we, mem_addr}), 32'({1'b1, 1'b0, 8'h00}));
        chk("wrap_fetch0", 32'({req2, addr2}), 32'({1'b1, 8'hFF}));
        tick();
        chk("wrap_pc", 32'({req2, pc2}), 32'({1'b0, 8'h00}));
        tick();
        chk("wrap_fetch1", 32'({req2, addr2}), 32'({1'b1, 8'h00}));
        repeat (7) tick();
        chk("halt_early", 32'(halted), 32'd0);
        tick();
        chk("halt_at_10", 32'(halted), 32'd1);
        chk("retires_4", 32'(retire_cnt), 32'd4);
        chk("prog1_store", 32'(mem[17]), 32'h0008);
        chk("prog1_acc_z", 32'({acc, zero}), 32'({16'h0008, 1'b0}));

        // Halted: no requests, stray acks ignored, resume fetches the next word.
        spur = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("halt_idle", 32'({mem_req, halted, pc}), 32'({1'b0, 1'b1, 8'h04}));
        end
        spur   = 1'b0;
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("resume_fetch", 32'({mem_req, mem_we, mem_addr, halted}), 32'({1'b1, 1'b0, 8'h04, 1'b0}));
        wait_halt("resume_halt", 50);
        chk("resume_pc", 32'({pc, 8'(retire_cnt)}), 32'({8'h05, 8'd5}));

        // Carry and zero out of an overflowing ADD, then a taken JZ.
        clear_mem();
        load(0, 16'h1040);
        load(1, 16'h3041);
        load(2, 16'hA020);
        load(32, 16'hF000);
        load(64, 16'hFFFF);
        load(65, 16'h0001);
        do_reset();
        wait_halt("cz_halt", 100);
        chk("cz_flags", 32'({acc, zero, carry}), 32'({16'h0000, 1'b1, 1'b1}));
        chk("jz_target", 32'(pc), 32'h21);

        // Three wait states on every access; same result as zero-wait.
        load_prog1();
        lat = 3;
        do_reset();
        wait_halt("ws_halt", 300);
        chk("ws_store", 32'(mem[17]), 32'h0008);
        chk("ws_state", 32'({acc, pc, 8'(retire_cnt)}), 32'({16'h0008, 8'h04, 8'd4}));

        // Reset while a store waits for ack, with ack forced high during reset.
        clear_mem();
        load(0, 16'h8007);
        load(1, 16'h2030);
        load(2, 16'hF000);
        lat = 3;
        do_reset();
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            tick();
            if (mem_req && mem_we) found = 1;
        end
        chk("store_seen", 32'(found), 32'd1);
        rst       = 1'b1;
        force_ack = 1'b1;
        #1;
        chk("rst_kills_req", 32'(mem_req), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        force_ack = 1'b0;
        tick();
        chk("rst_store_dropped", 32'(mem[48]), 32'h0000);
        chk("rst_refetch", 32'({mem_req, mem_we, mem_addr, pc}), 32'({1'b1, 1'b0, 8'h00, 8'h00}));
        chk("rst_acc_cleared", 32'(acc), 32'd0);
        wait_halt("rst_rerun_halt", 200);
        chk("rst_rerun_store", 32'(mem[48]), 32'h0007);

        // Random programs, random latency, random resume and stray acks.
        rand_lat = 1;
        for (int p = 0; p < 4; p++) begin
            clear_mem();
            for (int a = 0; a < 64; a++) begin
                logic [3:0] op;
                logic [7:0] opd;
                op = 4'($urandom_range(0, 15));
                if (op == 4'hF && $urandom_range(0, 1) == 0) op = 4'h0;
                if (op >= 4'h9 && op <= 4'hB) opd = 8'($urandom_range(0, 63));
                else if (op >= 4'h1 && op <= 4'h7) opd = 8'($urandom_range(64, 255));
                else opd = 8'($urandom);
                load(a, {op, 4'($urandom), opd});
            end
            for (int a = 64; a < 256; a++) load(a, 16'($urandom));
            do_reset();
            for (int c = 0; c < 500; c++) begin
                resume = ($urandom_range(0, 3) == 0);
                spur   = ($urandom_range(0, 1) == 1);
                tick();
            end
            resume = 1'b0;
            spur   = 1'b0;
            mism = 0;
            for (int a = 0; a < 256; a++) if (mem[a] !== mmem[a]) mism++;
            chk("rand_mem", 32'(mism), 32'd0);
            chk("rand_progress", 32'(retire_cnt > 20), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
